// File: rtl/com_fifo.sv
// Byte buffering between the UART primitives and the serial device controller:
// RX/TX circular FIFOs, a transmit drain state machine, and COM interrupt flags.
module com_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxdReady_i,
  input  logic [7:0]            rxdData_i,
  input  logic                  txdBusy_i,
  output logic                  txdStart_o,
  output logic [7:0]            txdData_o,
  input  logic                  rxPop_i,
  output logic [7:0]            rxData_o,
  output logic                  rxValid_o,
  output logic [DEPTH_LOG2:0]   rxCount_o,
  input  logic                  txPush_i,
  input  logic [7:0]            txData_i,
  output logic                  txFull_o,
  output logic [DEPTH_LOG2:0]   txCount_o,
  output logic                  overrun_o,
  input  logic                  clrOverrun_i,
  output logic                  int_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO
  } tx_state_t;

  tx_state_t state, state_nx;

  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];
  ptr_t       rx_wr, rx_rd, tx_wr, tx_rd;
  cnt_t       rx_cnt, tx_cnt;
  logic       overrun;

  logic rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  logic tx_full, tx_empty, tx_push, tx_pop;

  always_comb begin
    rx_full  = (rx_cnt == FULL_CNT);
    rx_empty = (rx_cnt == '0);
    tx_full  = (tx_cnt == FULL_CNT);
    tx_empty = (tx_cnt == '0);
    rx_pop   = rxPop_i && !rx_empty;
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    rx_push  = rxdReady_i && (!rx_full || rxPop_i);
    rx_drop  = rxdReady_i && rx_full && !rxPop_i;
    tx_pop   = (state == START);
    tx_push  = txPush_i && (!tx_full || tx_pop);
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rxdData_i;
    if (tx_push) tx_mem[tx_wr] <= txData_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr   <= '0;
      rx_rd   <= '0;
      rx_cnt  <= '0;
      tx_wr   <= '0;
      tx_rd   <= '0;
      tx_cnt  <= '0;
      overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + ptr_t'(1);
      if (rx_pop)  rx_rd <= rx_rd + ptr_t'(1);
      rx_cnt <= rx_cnt + cnt_t'(rx_push) - cnt_t'(rx_pop);
      if (tx_push) tx_wr <= tx_wr + ptr_t'(1);
      if (tx_pop)  tx_rd <= tx_rd + ptr_t'(1);
      tx_cnt <= tx_cnt + cnt_t'(tx_push) - cnt_t'(tx_pop);
      if (rx_drop)
        overrun <= 1'b1;
      else if (clrOverrun_i)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // After reset the FSM starts in IDLE, so a byte still on the line holds
  // off the next start through the busy check.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!tx_empty && !txdBusy_i) state_nx = START;
      START:   state_nx = WAIT_HI;
      WAIT_HI: if (txdBusy_i) state_nx = WAIT_LO;
      WAIT_LO: if (!txdBusy_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    txdStart_o = tx_pop;
    txdData_o  = tx_pop ? tx_mem[tx_rd] : '0;
    rxValid_o  = !rx_empty;
    rxData_o   = rx_empty ? '0 : rx_mem[rx_rd];
    rxCount_o  = rx_cnt;
    txCount_o  = tx_cnt;
    txFull_o   = tx_full;
    overrun_o  = overrun;
    int_o      = !rx_empty || overrun;
  end

endmodule

// File: tb/tb_com_fifo.sv
// Self-checking bench for com_fifo: table vectors, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_com_fifo;

  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxdReady, txdBusy, txdStart, rxPop, rxValid, txPush, txFull;
  logic          overrun, clrOv, intr;
  logic [7:0]    rxdData, txdData, rxData, txData;
  logic [DL:0]   rxCount, txCount;

  com_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .rxdReady_i(rxdReady), .rxdData_i(rxdData),
    .txdBusy_i(txdBusy), .txdStart_o(txdStart), .txdData_o(txdData),
    .rxPop_i(rxPop), .rxData_o(rxData), .rxValid_o(rxValid), .rxCount_o(rxCount),
    .txPush_i(txPush), .txData_i(txData), .txFull_o(txFull), .txCount_o(txCount),
    .overrun_o(overrun), .clrOverrun_i(clrOv), .int_o(intr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         ov_m = 1'b0;
  int         starts = 0;
  bit         prev_start = 1'b0, prev_busy = 1'b0, start_seen = 1'b0;
  int         bcnt = 0;
  bit         busy_force = 1'b0;

  assign txdBusy = (bcnt != 0) || busy_force;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy rises one edge after the start pulse, lasts 20 cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (start_seen) bcnt = 20;
    else if (bcnt > 0) bcnt--;
  end

  // Start-pulse monitor and TX scoreboard.
  initial forever begin
    @(negedge clk);
    if (txdStart) begin
      starts++;
      chk("start_while_busy", prev_busy, 0);
      chk("start_single_cycle", prev_start, 0);
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_extra_start: data %0h with no byte expected", txdData);
      end else begin
        chk("tx_data", txdData, tx_q.pop_front());
      end
    end
    prev_start = txdStart;
    prev_busy  = txdBusy;
    start_seen = txdStart;
  end

  task automatic step(input bit push, input logic [7:0] d, input bit pop, input bit clr,
                      input bit tpush, input logic [7:0] td);
    bit drop;
    rxdReady = push; rxdData = d; rxPop = pop; clrOv = clr; txPush = tpush; txData = td;
    @(posedge clk);
    drop = push && (rx_q.size() == 16) && !pop;
    if (pop && rx_q.size() > 0) rx_q.delete(0);
    if (push && !drop) rx_q.push_back(d);
    if (drop) ov_m = 1'b1;
    else if (clr) ov_m = 1'b0;
    if (tpush && tx_q.size() < 16) tx_q.push_back(td);
    #1;
    rxdReady = 1'b0; rxPop = 1'b0; clrOv = 1'b0; txPush = 1'b0;
    chk("rx_count", rxCount, rx_q.size());
    chk("rx_valid", rxValid, rx_q.size() != 0);
    if (rx_q.size() > 0) chk("rx_head", rxData, rx_q[0]);
    chk("overrun", overrun, ov_m);
    chk("int", intr, (rx_q.size() != 0) || ov_m);
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 0, 8'h00);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((tx_q.size() != 0 || txdBusy) && n < 400) begin
      idle();
      n++;
    end
    chk("tx_idle_reached", n < 400, 1);
    repeat (3) idle();
  endtask

  typedef struct {
    bit         push;
    logic [7:0] d;
    bit         pop;
    int         cnt;
    bit         vld;
    logic [7:0] head;
  } rx_vec_t;

  rx_vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;
    tbl[0] = '{1, 8'h41, 0, 1, 1, 8'h41};
    tbl[1] = '{1, 8'h42, 0, 2, 1, 8'h41};
    tbl[2] = '{1, 8'h43, 0, 3, 1, 8'h41};
    tbl[3] = '{0, 8'h00, 1, 2, 1, 8'h42};
    tbl[4] = '{0, 8'h00, 1, 1, 1, 8'h43};
    tbl[5] = '{0, 8'h00, 1, 0, 0, 8'h00};
    tbl[6] = '{0, 8'h00, 1, 0, 0, 8'h00};
    tbl[7] = '{1, 8'h77, 1, 1, 1, 8'h77};
    tbl[8] = '{0, 8'h00, 1, 0, 0, 8'h00};

    rst = 1'b1;
    rxdReady = 0; rxdData = 0; rxPop = 0; clrOv = 0; txPush = 0; txData = 0;
    repeat (2) @(negedge clk);
    chk("rst_rx_count", rxCount, 0);
    chk("rst_tx_count", txCount, 0);
    chk("rst_rx_valid", rxValid, 0);
    chk("rst_rx_data", rxData, 0);
    chk("rst_tx_full", txFull, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_int", intr, 0);
    chk("rst_txd_start", txdStart, 0);
    chk("rst_txd_data", txdData, 0);
    rst = 1'b0;

    // RX ordering, pop on empty, push+pop on empty
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].push, tbl[i].d, tbl[i].pop, 0, 0, 8'h00);
      chk($sformatf("vec%0d_count", i), rxCount, tbl[i].cnt);
      chk($sformatf("vec%0d_valid", i), rxValid, tbl[i].vld);
      chk($sformatf("vec%0d_int", i), intr, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("vec%0d_head", i), rxData, tbl[i].head);
    end

    // Overrun, clear, set-beats-clear, push-on-full with pop
    for (int i = 0; i <= 16; i++) step(1, 8'(i), 0, 0, 0, 8'h00);
    chk("ovr_count", rxCount, 16);
    chk("ovr_flag", overrun, 1);
    step(0, 8'h00, 0, 1, 0, 8'h00);
    chk("ovr_cleared", overrun, 0);
    step(1, 8'h99, 1, 0, 0, 8'h00);
    chk("full_pushpop_count", rxCount, 16);
    chk("full_pushpop_ovr", overrun, 0);
    chk("full_pushpop_head", rxData, 8'h01);
    step(1, 8'hBB, 0, 1, 0, 8'h00);
    chk("ovr_set_wins", overrun, 1);
    step(0, 8'h00, 0, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0, 8'h00);
    chk("ovr_drained", rxCount, 0);

    // Pointer wrap-around
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'hC0 + i), 0, 0, 0, 8'h00);
      chk("wrap_count", rxCount, 1);
      chk("wrap_head", rxData, 8'(8'hC0 + i));
      step(0, 8'h00, 1, 0, 0, 8'h00);
    end
    chk("wrap_ovr", overrun, 0);

    // TX drain of two bytes
    s0 = starts;
    step(0, 8'h00, 0, 0, 1, 8'h55);
    step(0, 8'h00, 0, 0, 1, 8'hAA);
    wait_tx_idle();
    chk("tx_drain_starts", starts - s0, 2);
    chk("tx_drain_count", txCount, 0);

    // TX full while transmitter held busy
    busy_force = 1'b1;
    s0 = starts;
    for (int i = 0; i < 16; i++) step(0, 8'h00, 0, 0, 1, 8'(8'hA0 + i));
    chk("txfull_count", txCount, 16);
    chk("txfull_flag", txFull, 1);
    step(0, 8'h00, 0, 0, 1, 8'hEE);
    chk("txfull_drop_count", txCount, 16);
    chk("txfull_no_start", starts - s0, 0);
    busy_force = 1'b0;
    wait_tx_idle();
    chk("txfull_sent", starts - s0, 16);
    chk("txfull_empty", txCount, 0);
    chk("txfull_clear", txFull, 0);

    // Asynchronous reset mid-operation
    busy_force = 1'b1;
    step(1, 8'h11, 0, 0, 1, 8'h01);
    step(1, 8'h22, 0, 0, 1, 8'h02);
    step(1, 8'h33, 0, 0, 0, 8'h00);
    chk("pre_rst_rx", rxCount, 3);
    chk("pre_rst_tx", txCount, 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_rx_count", rxCount, 0);
    chk("arst_tx_count", txCount, 0);
    chk("arst_start", txdStart, 0);
    chk("arst_int", intr, 0);
    chk("arst_rx_valid", rxValid, 0);
    rx_q.delete();
    tx_q.delete();
    ov_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    s0 = starts;
    step(0, 8'h00, 0, 0, 1, 8'h3C);
    repeat (10) idle();
    chk("arst_no_start_busy", starts - s0, 0);
    busy_force = 1'b0;
    n = 0;
    while (starts - s0 < 1 && n < 40) begin
      idle();
      n++;
    end
    chk("arst_resume_start", starts - s0, 1);
    wait_tx_idle();

    // Randomized RX/TX traffic; first half leans toward filling RX
    for (int i = 0; i < 600; i++) begin
      bit p, q, c, t;
      p = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      q = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 7) == 0) && (tx_q.size() < 14);
      step(p, 8'($urandom), q, c, t, 8'($urandom));
    end
    wait_tx_idle();
    chk("rand_tx_empty", txCount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/com_fifo.md
# com_fifo

Byte-buffering stage between the UART primitives (`async_receiver` / `async_transmitter`, 25 MHz, 9600 baud) and the serial device controller. Received bytes are queued in an RX FIFO instead of being lost when the CPU is slow. Bytes written by the CPU are queued in a TX FIFO and drained to the transmitter by a small state machine. It also provides a level interrupt and a sticky overrun flag for the COM interrupt line.

## Interface
- `DEPTH_LOG2`, 4: log2 of each FIFO depth (16 entries per FIFO)
- `clk` in 1: system clock (`clk25`)
- `rst` in 1: reset, asynchronous, active-high
- `rxdReady_i` in 1: one-cycle pulse from `async_receiver`, byte valid
- `rxdData_i` in 8: received byte
- `txdBusy_i` in 1: transmitter busy
- `txdStart_o` out 1: one-cycle start pulse to transmitter
- `txdData_o` out 8: byte to transmit, valid while `txdStart_o`=1
- `rxPop_i` in 1: consumer removes the RX head byte
- `rxData_o` out 8: RX head byte (first-word fall-through)
- `rxValid_o` out 1: RX FIFO not empty
- `rxCount_o` out DEPTH_LOG2+1: RX occupancy
- `txPush_i` in 1: consumer enqueues `txData_i`
- `txData_i` in 8: byte to enqueue
- `txFull_o` out 1: TX FIFO full
- `txCount_o` out DEPTH_LOG2+1: TX occupancy
- `overrun_o` out 1: sticky; an RX byte was dropped
- `clrOverrun_i` in 1: clears `overrun_o`
- `int_o` out 1: `rxValid_o | overrun_o`

## Operation
- Each FIFO is a circular buffer with DEPTH_LOG2-bit read and write pointers plus a (DEPTH_LOG2+1)-bit count. Pointers wrap modulo 2^DEPTH_LOG2. Full means count = 2^DEPTH_LOG2; empty means count = 0.
- **RX push:** on `rxdReady_i`, store `rxdData_i` at the write pointer if the FIFO is not full. If full and `rxPop_i` is not asserted in the same cycle, drop the byte and set `overrun_o`.
- **RX push while full with a simultaneous pop:** accept the push; count is unchanged.
- **RX pop:** `rxPop_i` while empty is ignored; pointers are unchanged. Push and pop on an empty FIFO: accept the push, ignore the pop, count becomes 1.
- **TX push:** `txPush_i` while full drops the byte silently. The consumer must check `txFull_o`. Push while full with a simultaneous internal pop (START state) is accepted.
- **TX state machine:**
  - IDLE: if TX is non-empty and `txdBusy_i`=0, go to START.
  - START: `txdStart_o`=1, `txdData_o` = TX head, pop TX, go to WAIT_HI.
  - WAIT_HI: wait for `txdBusy_i`=1, then go to WAIT_LO.
  - WAIT_LO: wait for `txdBusy_i`=0, then go to IDLE.
- **Overrun flag:** `clrOverrun_i` clears `overrun_o`. If a clear and a new overrun occur in the same cycle, set wins.
- **Reset** (async, any state, including mid-byte):
  - pointers and counts = 0, state = IDLE;
  - `txdStart_o`=0, `txdData_o`=0, `rxValid_o`=0, `rxData_o` = don't-care (0 in simulation), `txFull_o`=0, `overrun_o`=0, `int_o`=0.
  - A byte already started in the transmitter completes on the line. The block resumes in IDLE and waits for `txdBusy_i`=0 before issuing the next start.

## Timing
- All state updates on rising `clk`.
- `rxdReady_i` at edge N: `rxValid_o`/`rxCount_o` update after edge N. `rxData_o` shows the byte in the same cycle if the FIFO was empty (zero-latency fall-through after the write).
- `rxPop_i` at edge N: the next head appears after edge N.
- TX pipeline:
  - push at edge N makes the FIFO non-empty; IDLE→START at edge N+1;
  - `txdStart_o` is high for exactly the cycle after edge N+1;
  - minimum spacing between two start pulses is 4 cycles plus the transmitter busy time.
- `txdStart_o` is never asserted while `txdBusy_i`=1 was sampled on the previous edge.
- `int_o` is combinational from registered flags; no extra latency.

## Test plan
- **Reset mid-operation:** pulse `rst` with 3 RX and 2 TX bytes queued → all counts 0, `txdStart_o`=0, `int_o`=0 immediately (async); no start until `txdBusy_i` is low.
- **RX order:** pulse `rxdReady_i` with 0x41, 0x42, 0x43 → `rxCount_o`=3, `int_o`=1. Three pops read 0x41, 0x42, 0x43. After the last pop `rxValid_o`=0 and `int_o`=0. A fourth pop leaves count at 0.
- **Overrun:** push 17 bytes 0x00..0x10 with no pops → count 16, `overrun_o`=1, byte 0x10 absent. `clrOverrun_i` clears the flag. Push on full with a same-cycle pop → count stays 16, no overrun.
- **TX drain:** push 0x55, 0xAA with the transmitter model (busy 1 cycle after start, busy for 20 cycles) → two `txdStart_o` pulses carrying 0x55 then 0xAA. The second pulse comes no earlier than 1 cycle after busy falls, and never while busy.
- **TX full:** 16 pushes while busy is held high → `txFull_o`=1; a 17th push is dropped. After release, exactly 16 bytes are sent in order and `txCount_o` returns to 0.
- **Wrap-around:** 40 interleaved RX push/pop pairs (pointers wrap twice) → data order preserved, count never exceeds 1, no overrun.
